// File: rtl/dmem_bus_if.sv
// Data-side bus interface behind the MEM stage: turns a MEM request into one
// req/ack bus transaction, stalls the pipeline while it is outstanding, and
// hands the load result back. A WAIT-cycle timeout forces completion.
module dmem_bus_if #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mem_ce_i,
  input  logic                mem_we_i,
  input  logic [DATA_W/8-1:0] mem_sel_i,
  input  logic [ADDR_W-1:0]   mem_addr_i,
  input  logic [DATA_W-1:0]   mem_data_i,
  input  logic                stall_i,
  output logic [DATA_W-1:0]   mem_data_o,
  output logic                stallreq_o,
  output logic                bus_req_o,
  output logic                bus_we_o,
  output logic [DATA_W/8-1:0] bus_sel_o,
  output logic [ADDR_W-1:0]   bus_addr_o,
  output logic [DATA_W-1:0]   bus_wdata_o,
  input  logic                bus_ack_i,
  input  logic [DATA_W-1:0]   bus_rdata_i,
  output logic                bus_err_o
);
  localparam int SEL_W = DATA_W / 8;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_e;

  // Latched request driven onto the bus for the whole WAIT state.
  typedef struct packed {
    logic              we;
    logic [SEL_W-1:0]  sel;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } breq_t;

  state_e            state_q, state_d;
  breq_t             req_q, req_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              new_req;

  assign new_req = mem_ce_i && (|mem_sel_i);
  assign cnt_inc = cnt_q + CNT_W'(1);

  // State and datapath registers; reset abandons any in-flight transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Next-state: IDLE accepts, WAIT runs until ack or timeout (ack wins a tie),
  // DONE holds the result while the pipeline is frozen so nothing re-issues.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (new_req) begin
          req_d.we    = mem_we_i;
          req_d.sel   = mem_sel_i;
          req_d.addr  = mem_addr_i & ~ADDR_W'(3);
          req_d.wdata = mem_data_i;
          cnt_d       = '0;
          state_d     = WAIT;
        end
      end
      WAIT: begin
        if (bus_ack_i) begin
          rdata_d = req_q.we ? '0 : bus_rdata_i;
          state_d = DONE;
        end else if (cnt_inc == CNT_W'(TIMEOUT_CYCLES)) begin
          cnt_d   = cnt_inc;
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      DONE: begin
        if (!stall_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode from the current state so reset drops them immediately.
  always_comb begin
    stallreq_o  = (state_q == IDLE && new_req) || (state_q == WAIT);
    bus_req_o   = (state_q == WAIT);
    mem_data_o  = (state_q == DONE) ? rdata_q : '0;
    bus_we_o    = req_q.we;
    bus_sel_o   = req_q.sel;
    bus_addr_o  = req_q.addr;
    bus_wdata_o = req_q.wdata;
    bus_err_o   = err_q;
  end
endmodule

// File: tb/tb_dmem_bus_if.sv
// Directed plus randomized transactions against a transaction-level model:
// each access is summarised by when (if ever) the bus acks.
module tb_dmem_bus_if;
  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_ce_i, mem_we_i, stall_i, bus_ack_i;
  logic [3:0]  mem_sel_i;
  logic [31:0] mem_addr_i, mem_data_i, bus_rdata_i;
  logic [31:0] mem_data_o, bus_addr_o, bus_wdata_o;
  logic        stallreq_o, bus_req_o, bus_we_o, bus_err_o;
  logic [3:0]  bus_sel_o;

  int pass_cnt = 0;
  int total    = 0;
  logic err_m  = 1'b0;

  dmem_bus_if #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst),
    .mem_ce_i(mem_ce_i), .mem_we_i(mem_we_i), .mem_sel_i(mem_sel_i),
    .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i), .stall_i(stall_i),
    .mem_data_o(mem_data_o), .stallreq_o(stallreq_o), .bus_req_o(bus_req_o),
    .bus_we_o(bus_we_o), .bus_sel_o(bus_sel_o), .bus_addr_o(bus_addr_o),
    .bus_wdata_o(bus_wdata_o), .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i),
    .bus_err_o(bus_err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One access. k = WAIT cycle (1-based) in which the bus acks; k > T means never.
  task automatic run_txn(input string tag, input logic we, input logic [3:0] sel,
                         input logic [31:0] addr, input logic [31:0] data,
                         input logic [31:0] rdata, input int k, input int hold);
    int w, stall_n, req_n;
    logic tmo, ok, done;
    logic [31:0] exp_rd;
    w      = (k <= T) ? k : T;
    tmo    = (k > T);
    exp_rd = (!we && !tmo) ? rdata : 32'h0;
    err_m  = err_m | tmo;
    stall_n = 0; req_n = 0; ok = 1'b1; done = 1'b0;
    @(negedge clk);
    mem_ce_i = 1'b1; mem_we_i = we; mem_sel_i = sel;
    mem_addr_i = addr; mem_data_i = data; bus_ack_i = 1'b0; stall_i = 1'b0;
    #1;
    if (stallreq_o) stall_n++;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (bus_req_o) begin
        req_n++;
        if (bus_addr_o !== (addr & 32'hFFFF_FFFC) || bus_we_o !== we ||
            bus_sel_o !== sel || bus_wdata_o !== data) ok = 1'b0;
        bus_ack_i   = (req_n == k);
        bus_rdata_i = rdata;
      end else begin
        bus_ack_i = 1'b0;
      end
      if (stallreq_o) stall_n++;
      else done = 1'b1;
    end
    chk({tag, " completed"}, 64'(done), 64'd1);
    chk({tag, " stall cycles"}, 64'(stall_n), 64'(w + 1));
    chk({tag, " req cycles"}, 64'(req_n), 64'(w));
    chk({tag, " bus fields"}, 64'(ok), 64'd1);
    chk({tag, " done data"}, {31'h0, bus_req_o, mem_data_o}, {31'h0, 1'b0, exp_rd});
    chk({tag, " err"}, 64'(bus_err_o), 64'(err_m));
    stall_i = (hold > 0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({tag, " hold"}, {30'h0, bus_req_o, stallreq_o, mem_data_o}, {32'h0, exp_rd});
    end
    stall_i = 1'b0; mem_ce_i = 1'b0;
    @(negedge clk);
    chk({tag, " idle"}, {30'h0, bus_req_o, stallreq_o, mem_data_o}, 64'h0);
  endtask

  initial begin
    rst = 1'b1; mem_ce_i = 1'b0; mem_we_i = 1'b0; mem_sel_i = 4'h0;
    mem_addr_i = '0; mem_data_i = '0; stall_i = 1'b0; bus_ack_i = 1'b0; bus_rdata_i = '0;
    #12;
    chk("reset bus", {bus_req_o, bus_we_o, bus_sel_o, bus_addr_o}, 64'h0);
    chk("reset data", {bus_wdata_o, mem_data_o}, 64'h0);
    chk("reset flags", {62'h0, stallreq_o, bus_err_o}, 64'h0);
    @(negedge clk); rst = 1'b0;

    run_txn("load_ack1", 1'b0, 4'hF, 32'h0000_1006, 32'h0, 32'hDEAD_BEEF, 1, 0);
    run_txn("store_ack3", 1'b1, 4'b0011, 32'h0000_2000, 32'h1234_5678, 32'hFFFF_FFFF, 3, 0);
    run_txn("ack_at_timeout", 1'b0, 4'hF, 32'h0000_3003, 32'h0, 32'hCAFE_F00D, T, 0);
    run_txn("done_hold", 1'b0, 4'hC, 32'h0000_4008, 32'h0, 32'h5555_AAAA, 2, 3);

    // sel == 0: no transaction, no stall
    @(negedge clk);
    mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_sel_i = 4'h0; mem_addr_i = 32'h40;
    #1;
    chk("sel0 stall", 64'(stallreq_o), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("sel0 quiet", {30'h0, bus_req_o, stallreq_o, mem_data_o}, 64'h0);
    end
    mem_ce_i = 1'b0;

    run_txn("timeout", 1'b0, 4'hF, 32'h0000_5000, 32'h0, 32'h1111_2222, 99, 0);
    run_txn("after_timeout", 1'b0, 4'hF, 32'h0000_6000, 32'h0, 32'h3333_4444, 1, 1);

    for (int r = 0; r < 12; r++) begin
      run_txn("random", 1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)),
              $urandom, $urandom, $urandom, $urandom_range(1, T + 2),
              $urandom_range(0, 3));
    end

    // reset asynchronously in the middle of WAIT
    @(negedge clk);
    mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_sel_i = 4'hF; mem_addr_i = 32'h7000;
    bus_ack_i = 1'b0;
    @(negedge clk);
    chk("midwait req", 64'(bus_req_o), 64'd1);
    #2;
    rst = 1'b1; mem_ce_i = 1'b0;
    #1;
    chk("async reset drop", {61'h0, bus_req_o, stallreq_o, bus_err_o}, 64'h0);
    @(negedge clk); rst = 1'b0; err_m = 1'b0;
    run_txn("post_reset", 1'b0, 4'hF, 32'h0000_8004, 32'h0, 32'h0BAD_CAFE, 2, 0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/dmem_bus_if.md
Name: dmem_bus_if

Overview:
Data-side bus interface directly downstream of the MEM stage. It consumes the MEM stage's memory request (ce/we/sel/addr/data) and runs it as a req/ack transaction on the external data bus. While the transaction is outstanding it raises a pipeline stall request, then returns read data to MEM. A cycle timeout guarantees forward progress when the bus never acknowledges.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (sel width = DATA_W/8)
TIMEOUT_CYCLES, 255, WAIT cycles without ack before forced completion (≥1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
mem_ce_i  in  1  MEM stage request valid
mem_we_i  in  1  1 = store, 0 = load
mem_sel_i  in  DATA_W/8  byte enables
mem_addr_i  in  ADDR_W  byte address
mem_data_i  in  DATA_W  store data
stall_i  in  1  pipeline held by another source (MEM stage not advancing)
mem_data_o  out  DATA_W  load result to MEM stage
stallreq_o  out  1  stall request to stall_control
bus_req_o  out  1  bus request, held until ack
bus_we_o  out  1  write strobe
bus_sel_o  out  DATA_W/8  byte enables
bus_addr_o  out  ADDR_W  word address; bits [1:0] forced 0
bus_wdata_o  out  DATA_W  write data
bus_ack_i  in  1  transaction complete; rdata valid same cycle
bus_rdata_i  in  DATA_W  read data
bus_err_o  out  1  sticky timeout flag

Behaviour:
- Reset (async): state=IDLE. All bus_* outputs 0, mem_data_o=0, bus_err_o=0, timeout counter 0. An in-flight transaction is abandoned and bus_req_o drops immediately, without waiting for the clock.
- stallreq_o is combinational: (IDLE && mem_ce_i && mem_sel_i!=0) || WAIT.
- IDLE:
  - mem_ce_i=1 and sel!=0: latch we/sel/addr/wdata into the bus registers, clear the counter, go to WAIT. bus_req_o=1 from the next cycle.
  - mem_ce_i=1 and sel==0: no transaction and no stall; mem_data_o=0.
  - Otherwise stay in IDLE.
- WAIT:
  - bus_req_o=1; bus address, we, sel and wdata are stable for the whole state.
  - bus_ack_i=1: capture bus_rdata_i into the rdata register (captured on loads; 0 on stores), go to DONE. bus_req_o drops the next cycle.
  - No ack: counter += 1. When the counter reaches TIMEOUT_CYCLES, set bus_err_o=1, set the rdata register to 0, go to DONE.
  - Ack in the same cycle the timeout is reached: ack wins, no error.
- DONE:
  - stallreq_o=0 and bus_req_o=0; mem_data_o = rdata register.
  - stall_i=1: stay in DONE and hold rdata. No re-issue, even though mem_ce_i is still asserted with the same request.
  - stall_i=0: go to IDLE. The MEM request advances this edge.
- mem_data_o equals the rdata register only in DONE; otherwise 0.
- bus_ack_i is ignored in IDLE and DONE.
- Latency with ack on the first WAIT cycle: request seen in cycle N, bus_req_o high in N+1, ack in N+1, DONE in N+2. stallreq_o is high for cycles N and N+1.
- Back-to-back accesses: each request passes IDLE→WAIT→DONE→IDLE, so there are at least 3 cycles per access.
- Byte/halfword extraction and sign extension are done by the MEM stage; this block always transfers a full word with sel.
- bus_err_o stays set until reset.

Test Plan:
- Load, immediate ack: ce=1, we=0, sel=4'hF, addr=0x0000_1006; ack in the first WAIT cycle with rdata=0xDEADBEEF → bus_addr_o=0x0000_1004; stallreq_o high exactly 2 cycles; mem_data_o=0xDEADBEEF in DONE; one bus_req_o cycle only.
- Store, ack after 3 wait cycles: we=1, sel=4'b0011, data=0x1234_5678 → bus_we_o=1, bus_sel_o=4'b0011, bus_wdata_o=0x12345678 held stable 3 cycles; stallreq_o high 4 cycles; mem_data_o=0.
- Timeout: TIMEOUT_CYCLES=4, load, ack never arrives → DONE after 4 WAIT cycles; bus_err_o=1 and stays 1 over later accesses; mem_data_o=0.
- DONE hold: stall_i=1 for 3 cycles after completion while ce stays high → no second bus_req_o; mem_data_o stable; IDLE one cycle after stall_i falls.
- Reset mid-WAIT: assert rst between clock edges during WAIT → bus_req_o and stallreq_o drop 0 before the next edge; after release, a new load completes normally.
- Corner cases: ack coincident with the timeout cycle → no error, rdata captured. sel=0 with ce=1 → no bus_req_o and no stall.
